// File: rtl/gnrc_therm_counter.sv
// gnrc_therm_counter
// Registered thermometer-code up/down counter with saturation, parallel load
// and clear. It also has a valid/ready change notification so a consumer can
// follow every code update without polling.
//
// Parameters:
//   N           thermometer width (>=1)
//   INIT_LEVEL  number of ones after reset (0..N)
//   LW          level/load field width, derived from N (do not override)
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         synchronous reset, active-high
//   clr_i         clear to level 0 (beats load and inc/dec)
//   load_i        parallel load strobe (beats inc/dec)
//   load_level_i  level to load; values above N clamp to N
//   inc_i/dec_i   step up/down by one; both together do nothing
//   therm_o       registered LSB-filled thermometer code
//   level_o       registered count of ones in therm_o
//   full_o        therm_o is all ones
//   empty_o       therm_o is all zeros
//   ovf_o         one-cycle pulse: increment rejected at full
//   udf_o         one-cycle pulse: decrement rejected at empty
//   chg_valid_o   therm_o changed since the last accepted notification
//   chg_ready_i   consumer acknowledge for chg_valid_o
module gnrc_therm_counter #(
  parameter int unsigned N          = 3,
  parameter int unsigned INIT_LEVEL = 0,
  parameter int unsigned LW         = (N < 1) ? 1 : $clog2(N + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [LW-1:0] load_level_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [N-1:0]  therm_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          ovf_o,
  output logic          udf_o,
  output logic          chg_valid_o,
  input  logic          chg_ready_i
);

  localparam logic [LW-1:0] LEVEL_MAX  = LW'(N);
  localparam logic [LW-1:0] LEVEL_INIT = LW'(INIT_LEVEL);

  logic [N-1:0]  therm_q, therm_d, init_therm;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          chg_valid_q, chg_valid_d;
  logic [LW-1:0] load_clamped;

  assign load_clamped = (load_level_i > LEVEL_MAX) ? LEVEL_MAX : load_level_i;

  // The code is rebuilt from the level, so only legal thermometer codes can
  // ever be registered. Bit gi is set whenever the level exceeds gi.
  generate
    for (genvar gi = 0; gi < int'(N); gi++) begin : g_therm
      assign therm_d[gi]    = (level_d > LW'(gi));
      assign init_therm[gi] = (INIT_LEVEL > gi);
    end
  endgenerate

  always_comb begin
    level_d = level_q;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    if (clr_i) begin
      level_d = '0;
    end else if (load_i) begin
      level_d = load_clamped;
    end else if (inc_i && !dec_i) begin
      if (full_q) ovf_d = 1'b1;
      else        level_d = level_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (empty_q) udf_d = 1'b1;
      else         level_d = level_q - 1'b1;
    end
  end

  assign full_d  = (level_d == LEVEL_MAX);
  assign empty_d = (level_d == '0);
  // A new change in the handshake cycle re-arms valid straight away, and
  // several changes before an acknowledge merge into one notification.
  assign chg_valid_d = (therm_d != therm_q) | (chg_valid_q & ~chg_ready_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      therm_q     <= init_therm;
      level_q     <= LEVEL_INIT;
      full_q      <= (INIT_LEVEL == N);
      empty_q     <= (INIT_LEVEL == 0);
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      chg_valid_q <= 1'b0;
    end else begin
      therm_q     <= therm_d;
      level_q     <= level_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      chg_valid_q <= chg_valid_d;
    end
  end

  assign therm_o     = therm_q;
  assign level_o     = level_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign ovf_o       = ovf_q;
  assign udf_o       = udf_q;
  assign chg_valid_o = chg_valid_q;

endmodule

// File: doc/gnrc_therm_counter.md
Name: gnrc_therm_counter

Overview:
- Registered N-bit thermometer-code up/down counter with saturation, parallel load and clear.
- Produces the thermometer code consumed directly by the thermometer-to-onehot converter, e.g. level/credit/occupancy indicators.
- Includes a valid/ready change notification so a downstream consumer can track every code update without polling.

Parameters:
- N, 3, thermometer code width, range >=1.
- INIT_LEVEL, 0, number of ones in the code after reset, range 0..N.
- LW, $clog2(N+1) (min 1), level/load field width; auto-generated, do not override.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- clr_i  input  1  synchronous clear to level 0.
- load_i  input  1  parallel load strobe.
- load_level_i  input  LW  level to load; values >N clamp to N.
- inc_i  input  1  increment by one.
- dec_i  input  1  decrement by one.
- therm_o  output  N  registered thermometer code, LSB-filled (level k -> bits [k-1:0] set).
- level_o  output  LW  registered binary count of ones in therm_o.
- full_o  output  1  therm_o is all ones (level N).
- empty_o  output  1  therm_o is all zeros (level 0).
- ovf_o  output  1  one-cycle pulse: increment rejected at full.
- udf_o  output  1  one-cycle pulse: decrement rejected at empty.
- chg_valid_o  output  1  therm_o changed since the last accepted notification.
- chg_ready_i  input  1  consumer acknowledges the notification.

Behaviour:
- Reset:
  - therm_o = (1<<INIT_LEVEL)-1, level_o = INIT_LEVEL.
  - full_o = (INIT_LEVEL==N), empty_o = (INIT_LEVEL==0).
  - ovf_o = udf_o = chg_valid_o = 0.
- Priority per cycle: rst_i > clr_i > load_i > inc_i/dec_i.
- clr_i: next level 0; inc/dec/load ignored; no ovf/udf.
- load_i: next level min(load_level_i, N); inc/dec ignored; no ovf/udf.
- inc_i & !dec_i:
  - Not full: therm <= {therm[N-2:0],1'b1} (for N=1: 1'b1), level+1.
  - Full: no change, ovf_o=1 next cycle.
- dec_i & !inc_i:
  - Not empty: therm <= {1'b0,therm[N-1:1]}, level-1.
  - Empty: no change, udf_o=1 next cycle.
- inc_i & dec_i: no change, no ovf/udf, including at full or empty.
- Latency: all outputs are registered; effects appear one cycle after the strobe. full_o, empty_o and level_o are always consistent with therm_o in the same cycle.
- therm_o only ever holds legal thermometer codes; no illegal code is reachable.
- ovf_o and udf_o are single-cycle pulses; consecutive rejected strobes give consecutive pulses.
- Change notification:
  - Let chg = (next therm != current therm).
  - chg_valid_o next = chg | (chg_valid_o & !chg_ready_i).
  - A change in the same cycle as an accepted handshake keeps chg_valid_o high.
  - Load or clear to the current value is not a change.
  - chg_ready_i while chg_valid_o=0 has no effect.
  - Multiple changes before acknowledge coalesce into one notification; therm_o always shows the latest value.
- Reset mid-operation: state returns to INIT_LEVEL and pending notification and pulses are dropped in the same edge.

Test Plan:
- N=7, INIT_LEVEL=0, reset -> therm_o=0000000, level_o=0, empty_o=1, full_o=0, chg_valid_o=0.
- Increment sweep:
  - Stimulus: 8 consecutive inc_i, chg_ready_i=1.
  - Response: therm_o steps 0000001, 0000011, ... 1111111, one step per cycle; full_o=1 after the 7th.
  - 8th inc: therm_o unchanged, ovf_o=1 for exactly one cycle, chg_valid_o falls.
- Load then decrement:
  - load_i with load_level_i=3 -> therm_o=0000111, level_o=3.
  - Then 4 dec_i -> 0000011, 0000001, 0000000, then udf_o pulse with therm_o=0000000.
- Clamp and priority:
  - load_level_i=7 vs 5 on N=5: level 7 clamps to 11111.
  - clr_i together with load_i and inc_i -> therm_o=00000.
  - inc_i & dec_i at full -> no change, ovf_o=0, udf_o=0.
- Handshake:
  - chg_ready_i=0, 3 incs from 0 -> chg_valid_o stays 1, therm_o=0000111.
  - Ready pulse with no change -> chg_valid_o=0.
  - Ready pulse coinciding with an inc -> chg_valid_o remains 1.
  - load to the current level -> chg_valid_o stays 0.
- Mid-operation reset:
  - INIT_LEVEL=2, at level 6 with chg_valid_o=1 and inc_i asserted, rst_i for 1 cycle.
  - Response: therm_o=0000011, chg_valid_o=0, ovf_o=0.
